rect_fill_engine: RTL and testbench

//   Hardware rectangle-fill stage upstream of the framebuffer write port on gpu_clk.

---
 rtl/gpu_pkg.sv | 33 +++
 rtl/fb_strobe_gen.sv | 35 +++
 rtl/rect_fill_engine.sv | 285 ++++++++++++++++++++++++++++
 tb/tb_rect_fill_engine.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gpu_pkg.sv
// gpu_pkg: shared types and default geometry for the GPU fill path.
//   RES_X_DEFAULT / RES_Y_DEFAULT  default screen size in pixels / rows
//   FB_BYTES, FB_AW, fb_addr_t     framebuffer size and byte-address type (1 byte/pixel)
//   rect_cmd_t                     one fill command (x, y, w, h, color)
//   fill_state_e                   fill engine states
package gpu_pkg;

    localparam int RES_X_DEFAULT      = 400;
    localparam int RES_Y_DEFAULT      = 300;
    localparam int PIXEL_BITS_DEFAULT = 8;
    localparam int FB_BYTES           = RES_X_DEFAULT * RES_Y_DEFAULT;
    localparam int FB_AW              = $clog2(FB_BYTES);
    localparam int CMD_XW             = $clog2(RES_X_DEFAULT);
    localparam int CMD_YW             = $clog2(RES_Y_DEFAULT);

    typedef logic [FB_AW-1:0] fb_addr_t;

    typedef struct packed {
        logic [CMD_XW-1:0]             x;
        logic [CMD_YW-1:0]             y;
        logic [CMD_XW:0]               w;
        logic [CMD_YW:0]               h;
        logic [PIXEL_BITS_DEFAULT-1:0] color;
    } rect_cmd_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        FILL  = 2'd2,
        DONE  = 2'd3
    } fill_state_e;

endpackage

// File: rtl/fb_strobe_gen.sv
// fb_strobe_gen: byte-strobe mask for one 32-bit framebuffer word of a fill row.
//   first_i     word holds the row's left edge pixel
//   last_i      word holds the row's right edge pixel
//   x_lo_i      left edge byte lane (x[1:0])
//   x_end_lo_i  right edge byte lane (x_end[1:0])
//   strobe_o    byte enables, bit i = byte addr+i
module fb_strobe_gen (
    input  logic       first_i,
    input  logic       last_i,
    input  logic [1:0] x_lo_i,
    input  logic [1:0] x_end_lo_i,
    output logic [3:0] strobe_o
);

    logic [3:0] first_mask_s;
    logic [3:0] last_mask_s;

    // Lanes at or right of the left edge, lanes at or left of the right edge.
    always_comb begin
        first_mask_s = 4'hF;
        last_mask_s  = 4'hF;
        if (first_i) begin
            first_mask_s = 4'hF << x_lo_i;
        end else begin
            first_mask_s = 4'hF;
        end
        if (last_i) begin
            last_mask_s = 4'hF >> (2'd3 - x_end_lo_i);
        end else begin
            last_mask_s = 4'hF;
        end
        strobe_o = first_mask_s & last_mask_s;
    end

endmodule

// File: rtl/rect_fill_engine.sv
// rect_fill_engine: fills an axis-aligned rectangle with one palette index by
// issuing word-aligned 32-bit framebuffer writes with byte strobes.
//   clk, aresetn                clock, asynchronous active-low reset
//   cmd_valid/cmd_ready         command handshake (ready = engine idle)
//   cmd_x/y/w/h/color           rectangle origin, size and fill colour
//   fb_wr_valid/fb_wr_ready     write handshake to the framebuffer arbiter
//   fb_wr_addr/data/en          byte address (word aligned), {4{color}}, strobes
//   busy, done, cmd_err         status; done and cmd_err are 1-cycle pulses
// Build option: define RECT_FILL_CLIP_EN to clip rectangles at the screen edge
// instead of rejecting out-of-bounds commands.
module rect_fill_engine
    import gpu_pkg::*;
#(
    parameter int RESOLUTION_X = RES_X_DEFAULT,
    parameter int RESOLUTION_Y = RES_Y_DEFAULT,
    parameter int PIXEL_BITS   = PIXEL_BITS_DEFAULT
) (
    input  logic                                        clk,
    input  logic                                        aresetn,
    input  logic                                        cmd_valid,
    output logic                                        cmd_ready,
    input  logic [$clog2(RESOLUTION_X)-1:0]             cmd_x,
    input  logic [$clog2(RESOLUTION_Y)-1:0]             cmd_y,
    input  logic [$clog2(RESOLUTION_X):0]               cmd_w,
    input  logic [$clog2(RESOLUTION_Y):0]               cmd_h,
    input  logic [PIXEL_BITS-1:0]                       cmd_color,
    output logic                                        fb_wr_valid,
    input  logic                                        fb_wr_ready,
    output logic [$clog2(RESOLUTION_X*RESOLUTION_Y)-1:0] fb_wr_addr,
    output logic [31:0]                                 fb_wr_data,
    output logic [3:0]                                  fb_wr_en,
    output logic                                        busy,
    output logic                                        done,
    output logic                                        cmd_err
);

    localparam int XW = $clog2(RESOLUTION_X);
    localparam int YW = $clog2(RESOLUTION_Y);
    localparam int AW = $clog2(RESOLUTION_X * RESOLUTION_Y);
    localparam logic [XW+1:0] RX_L     = (XW+2)'(RESOLUTION_X);
    localparam logic [YW+1:0] RY_L     = (YW+2)'(RESOLUTION_Y);
    localparam logic [AW-1:0] ROW_STEP = AW'(RESOLUTION_X);

    // row * RESOLUTION_X as a sum of shifted copies; the set bits of the
    // constant select the terms, so no multiplier is built.
    function automatic logic [AW-1:0] row_offset(input logic [YW-1:0] row);
        logic [AW-1:0] acc;
        acc = '0;
        for (int i = 0; i < 31; i++) begin
            if (RESOLUTION_X[i] == 1'b1) begin
                acc = acc + (AW'(row) << i);
            end else begin
                acc = acc;
            end
        end
        return acc;
    endfunction

    fill_state_e       state_q, state_d;
    logic [XW-1:0]     x_q, x_d;
    logic [YW-1:0]     y_q, y_d;
    logic [XW:0]       w_q, w_d;
    logic [YW:0]       h_q, h_d;
    logic [PIXEL_BITS-1:0] color_q, color_d;
    logic              empty_q, empty_d;
    logic [XW:0]       x_end_q, x_end_d;
    logic [AW-1:0]     row_base_q, row_base_d;
    logic [YW:0]       rows_q, rows_d;
    logic [XW:0]       col_q, col_d;

    logic              cmd_ready_q, cmd_ready_d;
    logic              wr_valid_q, wr_valid_d;
    logic [AW-1:0]     wr_addr_q, wr_addr_d;
    logic [31:0]       wr_data_q, wr_data_d;
    logic [3:0]        wr_en_q, wr_en_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              cmd_err_q, cmd_err_d;

    logic              hs_s, wr_fire_s, off_screen_s, zero_size_s;
    logic              reject_s, empty_in_s;
    logic [XW:0]       x_end_calc_s;
    logic [YW:0]       rows_calc_s;
    logic [XW:0]       x_first_s, xe_word_s;
    logic              strobe_first_s, strobe_last_s;
    logic [3:0]        strobe_s;

    assign hs_s         = cmd_valid & cmd_ready_q;
    assign wr_fire_s    = wr_valid_q & fb_wr_ready;
    assign off_screen_s = ({2'b00, cmd_x} >= RX_L) | ({2'b00, cmd_y} >= RY_L);
    assign zero_size_s  = (cmd_w == '0) | (cmd_h == '0);
    assign x_first_s    = {1'b0, x_q[XW-1:2], 2'b00};
    assign xe_word_s    = {x_end_d[XW:2], 2'b00};

`ifdef RECT_FILL_CLIP_EN
    logic [XW+1:0] x_last_full_s;
    logic [YW+1:0] y_last_full_s;
    logic [YW:0]   y_end_s;

    // Command screening and SETUP geometry with right/bottom edge clipping.
    always_comb begin
        reject_s      = 1'b0;
        empty_in_s    = zero_size_s | off_screen_s;
        x_last_full_s = {2'b00, x_q} + {1'b0, w_q} - (XW+2)'(1);
        y_last_full_s = {2'b00, y_q} + {1'b0, h_q} - (YW+2)'(1);
        if (x_last_full_s > (RX_L - (XW+2)'(1))) begin
            x_end_calc_s = (XW+1)'(RESOLUTION_X - 1);
        end else begin
            x_end_calc_s = x_last_full_s[XW:0];
        end
        if (y_last_full_s > (RY_L - (YW+2)'(1))) begin
            y_end_s = (YW+1)'(RESOLUTION_Y - 1);
        end else begin
            y_end_s = y_last_full_s[YW:0];
        end
        rows_calc_s = y_end_s - {1'b0, y_q} + (YW+1)'(1);
    end
`else
    logic [XW+1:0] x_sum_s;
    logic [YW+1:0] y_sum_s;

    // Command screening (reject anything leaving the screen) and SETUP geometry.
    always_comb begin
        x_sum_s      = {2'b00, cmd_x} + {1'b0, cmd_w};
        y_sum_s      = {2'b00, cmd_y} + {1'b0, cmd_h};
        reject_s     = off_screen_s | (x_sum_s > RX_L) | (y_sum_s > RY_L);
        empty_in_s   = zero_size_s;
        x_end_calc_s = {1'b0, x_q} + w_q - (XW+1)'(1);
        rows_calc_s  = h_q;
    end
`endif

    // Next-state and next-output logic; outputs are registered from the next state.
    always_comb begin
        state_d    = state_q;
        x_d        = x_q;
        y_d        = y_q;
        w_d        = w_q;
        h_d        = h_q;
        color_d    = color_q;
        empty_d    = empty_q;
        x_end_d    = x_end_q;
        row_base_d = row_base_q;
        rows_d     = rows_q;
        col_d      = col_q;
        cmd_err_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (hs_s) begin
                    x_d     = cmd_x;
                    y_d     = cmd_y;
                    w_d     = cmd_w;
                    h_d     = cmd_h;
                    color_d = cmd_color;
                    empty_d = empty_in_s;
                    if (reject_s) begin
                        cmd_err_d = 1'b1;
                        state_d   = IDLE;
                    end else begin
                        state_d   = SETUP;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            SETUP: begin
                x_end_d    = x_end_calc_s;
                row_base_d = row_offset(y_q);
                rows_d     = rows_calc_s;
                col_d      = x_first_s;
                if (empty_q) begin
                    state_d = DONE;
                end else begin
                    state_d = FILL;
                end
            end
            FILL: begin
                if (wr_fire_s) begin
                    if (col_q == xe_word_s) begin
                        if (rows_q == {{YW{1'b0}}, 1'b1}) begin
                            state_d = DONE;
                        end else begin
                            // Next row starts in the very next cycle.
                            rows_d     = rows_q - {{YW{1'b0}}, 1'b1};
                            row_base_d = row_base_q + ROW_STEP;
                            col_d      = x_first_s;
                        end
                    end else begin
                        col_d = col_q + (XW+1)'(4);
                    end
                end else begin
                    state_d = FILL;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        cmd_ready_d = (state_d == IDLE);
        busy_d      = (state_d == SETUP) || (state_d == FILL);
        done_d      = (state_d == DONE);
        wr_valid_d  = (state_d == FILL);
        // While stalled the _d values equal the _q values, so the bus holds.
        if (state_d == FILL) begin
            wr_addr_d = row_base_d + AW'(col_d);
            wr_data_d = {4{color_d}};
            wr_en_d   = strobe_s;
        end else begin
            wr_addr_d = '0;
            wr_data_d = 32'h0000_0000;
            wr_en_d   = 4'h0;
        end
    end

    assign strobe_first_s = (col_d == x_first_s);
    assign strobe_last_s  = (col_d == xe_word_s);

    fb_strobe_gen u_strobe (
        .first_i    (strobe_first_s),
        .last_i     (strobe_last_s),
        .x_lo_i     (x_q[1:0]),
        .x_end_lo_i (x_end_d[1:0]),
        .strobe_o   (strobe_s)
    );

    // State, command and output registers.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state_q     <= IDLE;
            x_q         <= '0;
            y_q         <= '0;
            w_q         <= '0;
            h_q         <= '0;
            color_q     <= '0;
            empty_q     <= 1'b0;
            x_end_q     <= '0;
            row_base_q  <= '0;
            rows_q      <= '0;
            col_q       <= '0;
            cmd_ready_q <= 1'b0;
            wr_valid_q  <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= 32'h0000_0000;
            wr_en_q     <= 4'h0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            cmd_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            y_q         <= y_d;
            w_q         <= w_d;
            h_q         <= h_d;
            color_q     <= color_d;
            empty_q     <= empty_d;
            x_end_q     <= x_end_d;
            row_base_q  <= row_base_d;
            rows_q      <= rows_d;
            col_q       <= col_d;
            cmd_ready_q <= cmd_ready_d;
            wr_valid_q  <= wr_valid_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            wr_en_q     <= wr_en_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            cmd_err_q   <= cmd_err_d;
        end
    end

    assign cmd_ready   = cmd_ready_q;
    assign fb_wr_valid = wr_valid_q;
    assign fb_wr_addr  = wr_addr_q;
    assign fb_wr_data  = wr_data_q;
    assign fb_wr_en    = wr_en_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign cmd_err     = cmd_err_q;

endmodule

// File: tb/tb_rect_fill_engine.sv
// Bench for rect_fill_engine: directed cases plus randomized commands checked
// against a pixel-level reference model of which bytes each rectangle covers.
module tb_rect_fill_engine;
    import gpu_pkg::*;

    localparam int RX = RES_X_DEFAULT;
    localparam int RY = RES_Y_DEFAULT;

    logic                  clk;
    logic                  aresetn;
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [CMD_XW-1:0]     cmd_x;
    logic [CMD_YW-1:0]     cmd_y;
    logic [CMD_XW:0]       cmd_w;
    logic [CMD_YW:0]       cmd_h;
    logic [7:0]            cmd_color;
    logic                  fb_wr_valid;
    logic                  fb_wr_ready;
    fb_addr_t              fb_wr_addr;
    logic [31:0]           fb_wr_data;
    logic [3:0]            fb_wr_en;
    logic                  busy;
    logic                  done;
    logic                  cmd_err;

    int n_tests = 0;
    int n_fail  = 0;

    fb_addr_t   exp_addr[$];
    logic [3:0] exp_en[$];
    fb_addr_t   log_addr[$];
    logic [3:0] log_en[$];

    rect_fill_engine dut (
        .clk         (clk),
        .aresetn     (aresetn),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_x       (cmd_x),
        .cmd_y       (cmd_y),
        .cmd_w       (cmd_w),
        .cmd_h       (cmd_h),
        .cmd_color   (cmd_color),
        .fb_wr_valid (fb_wr_valid),
        .fb_wr_ready (fb_wr_ready),
        .fb_wr_addr  (fb_wr_addr),
        .fb_wr_data  (fb_wr_data),
        .fb_wr_en    (fb_wr_en),
        .busy        (busy),
        .done        (done),
        .cmd_err     (cmd_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: walk every covered pixel, group by aligned 4-byte word.
    task automatic build_model(input int x, input int y, input int w, input int h, output bit rej);
        int xe;
        int ye;
        bit empty;
        logic [3:0] en;
        exp_addr.delete();
        exp_en.delete();
`ifdef RECT_FILL_CLIP_EN
        rej   = 1'b0;
        empty = (w == 0) || (h == 0) || (x >= RX) || (y >= RY);
        xe    = (x + w - 1 > RX - 1) ? RX - 1 : x + w - 1;
        ye    = (y + h - 1 > RY - 1) ? RY - 1 : y + h - 1;
`else
        rej   = (x >= RX) || (y >= RY) || (x + w > RX) || (y + h > RY);
        empty = (w == 0) || (h == 0);
        xe    = x + w - 1;
        ye    = y + h - 1;
`endif
        if (!rej && !empty) begin
            for (int r = y; r <= ye; r++) begin
                for (int wb = x - (x % 4); wb <= xe; wb += 4) begin
                    en = 4'h0;
                    for (int b = 0; b < 4; b++) begin
                        if ((wb + b >= x) && (wb + b <= xe)) en[b] = 1'b1;
                    end
                    exp_addr.push_back(fb_addr_t'(r * RX + wb));
                    exp_en.push_back(en);
                end
            end
        end
    endtask

    // Offer a command; returns #1 after the handshake edge.
    task automatic issue_cmd(input int x, input int y, input int w, input int h, input logic [7:0] c);
        int n;
        cmd_x     = CMD_XW'(x);
        cmd_y     = CMD_YW'(y);
        cmd_w     = (CMD_XW+1)'(w);
        cmd_h     = (CMD_YW+1)'(h);
        cmd_color = c;
        cmd_valid = 1'b1;
        n = 0;
        while (!cmd_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check_val("cmd_ready_wait", cmd_ready, 1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    // mode 0: ready always high, 1: ready toggles, 2: random ready.
    task automatic run_cmd(input int x, input int y, input int w, input int h,
                           input logic [7:0] c, input int mode);
        int k, done_k, last_k, nexp, nfire, busy_bad, bad;
        bit rej, got_done, prev_stall, rdy;
        logic [53:0] prev_bus;
        build_model(x, y, w, h, rej);
        nexp = exp_addr.size();
        log_addr.delete();
        log_en.delete();
        fb_wr_ready = 1'b1;
        issue_cmd(x, y, w, h, c);
        if (rej) begin
            check_val("rej_err_pulse", cmd_err, 1);
            check_val("rej_busy", busy, 0);
            bad = 0;
            for (int i = 0; i < 6; i++) begin
                if (fb_wr_valid || done) bad++;
                @(posedge clk); #1;
                if (cmd_err) bad++;
            end
            check_val("rej_quiet", bad, 0);
            return;
        end
        check_val("cmd_err_quiet", cmd_err, 0);
        k = 1; done_k = 0; last_k = 0; nfire = 0; busy_bad = 0;
        got_done = 1'b0; prev_stall = 1'b0; prev_bus = '0;
        while (!got_done && k < 3000) begin
            if (prev_stall)
                check_val("stall_hold", {fb_wr_valid, fb_wr_addr, fb_wr_en, fb_wr_data}, prev_bus);
            if (done) begin
                got_done = 1'b1;
                done_k   = k;
                check_val("done_busy", busy, 0);
            end else begin
                if (!busy) busy_bad++;
                rdy = (mode == 0) ? 1'b1 : (mode == 1) ? k[0] : 1'($urandom_range(0, 1));
                fb_wr_ready = rdy;
                prev_stall  = fb_wr_valid && !rdy;
                prev_bus    = {fb_wr_valid, fb_wr_addr, fb_wr_en, fb_wr_data};
                if (fb_wr_valid && rdy) begin
                    nfire++;
                    last_k = k;
                    log_addr.push_back(fb_wr_addr);
                    log_en.push_back(fb_wr_en);
                    if (exp_addr.size() > 0) begin
                        check_val("wr_addr", fb_wr_addr, exp_addr.pop_front());
                        check_val("wr_en", fb_wr_en, exp_en.pop_front());
                        check_val("wr_data", fb_wr_data, {4{c}});
                    end
                end
                @(posedge clk); #1;
                k++;
            end
        end
        fb_wr_ready = 1'b1;
        check_val("done_seen", got_done, 1);
        if (got_done) begin
            check_val("done_time", done_k, (nexp == 0) ? 2 : last_k + 1);
            check_val("write_count", nfire, nexp);
            check_val("busy_span", busy_bad, 0);
            if (mode == 0) check_val("throughput", last_k, (nexp == 0) ? 0 : nexp + 1);
            @(posedge clk); #1;
            check_val("ready_after_done", cmd_ready, 1);
            check_val("done_one_cycle", done, 0);
        end
    endtask

    initial begin
        int bad, x, y, w, h, r;
        aresetn     = 1'b0;
        cmd_valid   = 1'b0;
        cmd_x       = '0;
        cmd_y       = '0;
        cmd_w       = '0;
        cmd_h       = '0;
        cmd_color   = 8'h00;
        fb_wr_ready = 1'b1;
        #1;
        check_val("reset_outputs",
                  {cmd_ready, fb_wr_valid, fb_wr_en, fb_wr_addr, fb_wr_data, busy, done, cmd_err}, 0);
        repeat (2) @(posedge clk);
        #1;
        aresetn = 1'b1;
        check_val("ready_low_at_release", cmd_ready, 0);
        @(posedge clk); #1;
        check_val("ready_after_release", cmd_ready, 1);

        // Directed cases.
        run_cmd(0, 0, 4, 1, 8'h5A, 0);
        check_val("t1_addr", log_addr.size() > 0 ? log_addr[0] : fb_addr_t'(1), 0);
        check_val("t1_en", log_en.size() > 0 ? log_en[0] : 4'h0, 4'hF);
        run_cmd(1, 2, 6, 1, 8'h11, 0);
        check_val("t2_addr0", log_addr.size() > 1 ? log_addr[0] : fb_addr_t'(0), 800);
        check_val("t2_en0", log_en.size() > 1 ? log_en[0] : 4'h0, 4'b1110);
        check_val("t2_addr1", log_addr.size() > 1 ? log_addr[1] : fb_addr_t'(0), 804);
        check_val("t2_en1", log_en.size() > 1 ? log_en[1] : 4'h0, 4'b0111);
        run_cmd(2, 0, 1, 3, 8'h22, 2);
        run_cmd(0, 7, 400, 1, 8'h33, 1);
        check_val("full_row_words", log_addr.size(), 100);
        run_cmd(398, 10, 8, 1, 8'h44, 0);
`ifdef RECT_FILL_CLIP_EN
        check_val("clip_en", log_en.size() == 1 ? log_en[0] : 4'h0, 4'b1100);
`endif
        run_cmd(5, 5, 0, 3, 8'h55, 0);
        run_cmd(450, 5, 4, 1, 8'h66, 0);
        run_cmd(396, 297, 4, 3, 8'h77, 2);

        // Reset in the middle of a 40x40 fill.
        fb_wr_ready = 1'b1;
        issue_cmd(0, 0, 40, 40, 8'hC3);
        repeat (30) begin
            @(posedge clk); #1;
        end
        check_val("midfill_active", fb_wr_valid, 1);
        aresetn = 1'b0;
        #1;
        check_val("rst_valid_drop", fb_wr_valid, 0);
        check_val("rst_busy_drop", busy, 0);
        bad = 0;
        repeat (3) begin
            @(posedge clk); #1;
            if (fb_wr_valid || done || cmd_ready) bad++;
        end
        aresetn = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            if (fb_wr_valid || done) bad++;
        end
        check_val("post_reset_quiet", bad, 0);
        run_cmd(3, 5, 9, 2, 8'h9C, 0);

        // Randomized commands, mixing in-bounds, empty and out-of-bounds cases.
        for (int i = 0; i < 40; i++) begin
            r = $urandom_range(0, 9);
            x = $urandom_range(0, 399);
            y = $urandom_range(0, 299);
            w = $urandom_range(1, 12);
            h = $urandom_range(1, 3);
            if (x + w > RX) w = RX - x;
            if (y + h > RY) h = RY - y;
            if (r == 6) begin
                if ($urandom_range(0, 1) == 1) w = 0; else h = 0;
            end else if (r == 7) begin
                x = $urandom_range(390, 399);
                w = $urandom_range(11, 20);
            end else if (r == 8) begin
                y = $urandom_range(297, 299);
                h = $urandom_range(4, 6);
            end else if (r == 9) begin
                x = $urandom_range(400, 511);
            end
            run_cmd(x, y, w, h, 8'($urandom), i % 3);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: time limit reached before the summary");
        $fatal(1, "watchdog");
    end

endmodule
